// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between the AXI-to-APB bridge (master) and one register completer (slave).
// Signal names keep the completer's point of view so both sides read the same.
interface apb_reg_slave_if;
  logic        iPSEL;
  logic        iPENABLE;
  logic        iPWRITE;
  logic [15:0] iPADDR;
  logic [31:0] iPWDATA;
  logic [31:0] oPRDATA;
  logic        oPREADY;

  modport master (
    output iPSEL, iPENABLE, iPWRITE, iPADDR, iPWDATA,
    input  oPRDATA, oPREADY
  );

  modport slave (
    input  iPSEL, iPENABLE, iPWRITE, iPADDR, iPWDATA,
    output oPRDATA, oPREADY
  );
endinterface

// File: rtl/apb_reg_slave.sv
// APB completer with a word-indexed 32-bit register bank and a programmable number of
// wait states before PREADY; reg0 is a constant ID, reg1 drives oCtrl, reg2 mirrors iStatus.
module apb_reg_slave #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'h7000_A5A5
) (
  input  logic              iClk,
  input  logic              iRsn,
  apb_reg_slave_if.slave    apb,
  input  logic [31:0]       iStatus,
  output logic [31:0]       oCtrl
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // The wait counter is only 4 bits wide, so larger wait counts cannot be honoured.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gBadWait
    $error("apb_reg_slave: WAIT_CYCLES must be in 0..15");
  end
  if (NUM_REGS < 3 || NUM_REGS > 16384) begin : gBadRegs
    $error("apb_reg_slave: NUM_REGS must be in 3..16384");
  end

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t      stateQ, stateD;
  logic [3:0]  countQ, countD;
  logic        readyQ, readyD;
  logic [13:0] idxQ;
  logic        writeQ;
  logic [31:0] prdataQ;
  logic [31:0] readData;
  logic [31:0] regs [NUM_REGS];
  logic [13:0] addrIdx;
  logic        setupEvt;
  logic        completeEvt;
  logic        abortEvt;
  logic        commitEvt;
  logic        idxWritable;

  assign addrIdx = apb.iPADDR[15:2];

  always_comb begin
    stateD      = stateQ;
    countD      = countQ;
    setupEvt    = 1'b0;
    completeEvt = 1'b0;
    abortEvt    = 1'b0;
    case (stateQ)
      IDLE: begin
        if (apb.iPSEL && !apb.iPENABLE) begin
          stateD   = ACCESS;
          countD   = 4'(WAIT_CYCLES);
          setupEvt = 1'b1;
        end
      end
      ACCESS: begin
        if (!apb.iPSEL) begin
          stateD   = IDLE;
          countD   = 4'd0;
          abortEvt = 1'b1;
        end else if (countQ != 4'd0) begin
          countD = countQ - 4'd1;
        end else if (apb.iPENABLE) begin
          stateD      = IDLE;
          completeEvt = 1'b1;
        end
      end
      default: begin
        stateD = IDLE;
        countD = 4'd0;
      end
    endcase
  end

  // PREADY is registered from the next-state decode so the bridge sees a clean flop output.
  assign readyD = (stateD == ACCESS) && (countD == 4'd0);

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      stateQ <= IDLE;
      countQ <= 4'd0;
      readyQ <= 1'b0;
      idxQ   <= '0;
      writeQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      countQ <= countD;
      readyQ <= readyD;
      if (setupEvt) begin
        idxQ   <= addrIdx;
        writeQ <= apb.iPWRITE;
      end
    end
  end

  always_comb begin
    readData = '0;
    if (addrIdx == 14'd0) begin
      readData = ID_VALUE;
    end else if (addrIdx == 14'd2) begin
      readData = iStatus;
    end else if (addrIdx < 14'(NUM_REGS)) begin
      readData = regs[addrIdx[IDX_W-1:0]];
    end
  end

  // Read data is captured at the setup edge, so iStatus is a snapshot from that cycle.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      prdataQ <= '0;
    end else if (setupEvt && !apb.iPWRITE) begin
      prdataQ <= readData;
    end else if (completeEvt || abortEvt) begin
      prdataQ <= '0;
    end
  end

  assign idxWritable = (idxQ == 14'd1) ||
                       ((idxQ >= 14'd3) && (idxQ < 14'(NUM_REGS)));
  assign commitEvt   = completeEvt && writeQ && idxWritable;

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commitEvt) begin
      regs[idxQ[IDX_W-1:0]] <= apb.iPWDATA;
    end
  end

  assign apb.oPREADY = readyQ;
  assign apb.oPRDATA = prdataQ;
  assign oCtrl       = regs[1];

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: one instance with two wait states, one with none, checked by
// a constant vector table, hand sequences for abort/reset/back-to-back, and a random run.
module tb_apb_reg_slave;

  localparam logic [31:0] ID = 32'h7000_A5A5;

  logic        iClk = 1'b0;
  logic        iRsn = 1'b0;
  logic [31:0] status = '0;
  logic [31:0] ctrlW, ctrlZ;
  int          cycCnt = 0;
  int          nVec = 0;
  int          nMis = 0;
  logic [31:0] model [2][16];

  apb_reg_slave_if busW ();
  apb_reg_slave_if busZ ();

  apb_reg_slave #(.NUM_REGS(16), .WAIT_CYCLES(2), .ID_VALUE(ID)) dutW (
    .iClk(iClk), .iRsn(iRsn), .apb(busW.slave), .iStatus(status), .oCtrl(ctrlW)
  );

  apb_reg_slave #(.NUM_REGS(16), .WAIT_CYCLES(0), .ID_VALUE(ID)) dutZ (
    .iClk(iClk), .iRsn(iRsn), .apb(busZ.slave), .iStatus(status), .oCtrl(ctrlZ)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cycCnt <= cycCnt + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    bit          isWrite;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] stat;
    logic [31:0] expRdata;
    logic [31:0] expCtrl;
  } vec_t;

  vec_t vecs [11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic driveBus(input bit z, input logic psel, input logic pen, input logic pwr,
                          input logic [15:0] addr, input logic [31:0] wdata);
    if (z) begin
      busZ.iPSEL = psel; busZ.iPENABLE = pen; busZ.iPWRITE = pwr;
      busZ.iPADDR = addr; busZ.iPWDATA = wdata;
    end else begin
      busW.iPSEL = psel; busW.iPENABLE = pen; busW.iPWRITE = pwr;
      busW.iPADDR = addr; busW.iPWDATA = wdata;
    end
  endtask

  function automatic logic curReady(input bit z);
    return z ? busZ.oPREADY : busW.oPREADY;
  endfunction

  function automatic logic [31:0] curRdata(input bit z);
    return z ? busZ.oPRDATA : busW.oPRDATA;
  endfunction

  function automatic logic [31:0] curCtrl(input bit z);
    return z ? ctrlZ : ctrlW;
  endfunction

  // Reference register map: word index from the byte address, only 1 and 3..15 hold data.
  function automatic void modelWrite(input bit z, input logic [15:0] addr, input logic [31:0] d);
    int idx;
    idx = int'(addr[15:2]);
    if (idx == 1 || (idx >= 3 && idx < 16)) model[z][idx] = d;
  endfunction

  function automatic logic [31:0] modelRead(input bit z, input logic [15:0] addr, input logic [31:0] st);
    int idx;
    idx = int'(addr[15:2]);
    if (idx == 0) return ID;
    if (idx == 2) return st;
    if (idx < 16) return model[z][idx];
    return 32'h0;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 16; i++) begin
      model[0][i] = '0;
      model[1][i] = '0;
    end
  endfunction

  // Called just after a rising edge; returns just after the edge following completion.
  task automatic applyStimulus(input bit z, input bit wr, input logic [15:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output int span);
    int  t0;
    bit  seen;
    t0    = cycCnt;
    rdata = '0;
    seen  = 1'b0;
    driveBus(z, 1'b1, 1'b0, wr, addr, wdata);
    @(posedge iClk); #1;
    driveBus(z, 1'b1, 1'b1, wr, addr, wdata);
    for (int acc = 1; acc <= 20; acc++) begin
      @(negedge iClk);
      if (curReady(z)) begin
        seen  = 1'b1;
        rdata = curRdata(z);
        break;
      end
      @(posedge iClk); #1;
    end
    if (!seen) checkOutput("readyTimeout", 32'd0, 32'd1);
    @(posedge iClk); #1;
    driveBus(z, 1'b0, 1'b0, 1'b0, addr, wdata);
    span = cycCnt - t0;
  endtask

  task automatic abortXfer(input bit z, input logic [15:0] addr, input logic [31:0] wdata,
                           input int hold);
    driveBus(z, 1'b1, 1'b0, 1'b1, addr, wdata);
    @(posedge iClk); #1;
    for (int i = 0; i < hold; i++) begin
      driveBus(z, 1'b1, 1'b1, 1'b1, addr, wdata);
      @(posedge iClk); #1;
    end
    driveBus(z, 1'b0, 1'b0, 1'b1, addr, wdata);
    @(posedge iClk); #1;
    checkOutput("abortReadyLow", 32'(curReady(z)), 32'd0);
    driveBus(z, 1'b0, 1'b0, 1'b0, addr, wdata);
  endtask

  initial begin
    logic [31:0] rd;
    int          span;
    modelReset();
    driveBus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    driveBus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);

    vecs[0]  = '{1'b1, 16'h0004, 32'h1234_5678, 32'h0,         32'h0,         32'h1234_5678};
    vecs[1]  = '{1'b0, 16'h0004, 32'h0,         32'h0,         32'h1234_5678, 32'h1234_5678};
    vecs[2]  = '{1'b0, 16'h0000, 32'h0,         32'h0,         32'h7000_A5A5, 32'h1234_5678};
    vecs[3]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h1234_5678};
    vecs[4]  = '{1'b0, 16'h0000, 32'h0,         32'h0,         32'h7000_A5A5, 32'h1234_5678};
    vecs[5]  = '{1'b0, 16'h0008, 32'h0,         32'hCAFE_0001, 32'hCAFE_0001, 32'h1234_5678};
    vecs[6]  = '{1'b1, 16'h0040, 32'h0000_0001, 32'hCAFE_0001, 32'h0,         32'h1234_5678};
    vecs[7]  = '{1'b0, 16'h0040, 32'h0,         32'hCAFE_0001, 32'h0,         32'h1234_5678};
    vecs[8]  = '{1'b0, 16'h0004, 32'h0,         32'hCAFE_0001, 32'h1234_5678, 32'h1234_5678};
    vecs[9]  = '{1'b1, 16'h000C, 32'hAAAA_5555, 32'hCAFE_0001, 32'h0,         32'h1234_5678};
    vecs[10] = '{1'b0, 16'h000C, 32'h0,         32'hCAFE_0001, 32'hAAAA_5555, 32'h1234_5678};

    // Reset state
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    checkOutput("resetReadyW", 32'(busW.oPREADY), 32'd0);
    checkOutput("resetRdataW", busW.oPRDATA, 32'd0);
    checkOutput("resetCtrlW", ctrlW, 32'd0);
    checkOutput("resetReadyZ", 32'(busZ.oPREADY), 32'd0);
    checkOutput("resetCtrlZ", ctrlZ, 32'd0);
    iRsn = 1'b1;
    @(posedge iClk); #1;

    // Constant vector table on the two-wait-state instance
    for (int v = 0; v < 11; v++) begin
      status = vecs[v].stat;
      applyStimulus(1'b0, vecs[v].isWrite, vecs[v].addr, vecs[v].wdata, rd, span);
      if (vecs[v].isWrite) modelWrite(1'b0, vecs[v].addr, vecs[v].wdata);
      else checkOutput($sformatf("vec%0d.rdata", v), rd, vecs[v].expRdata);
      checkOutput($sformatf("vec%0d.span", v), 32'(span), 32'd4);
      checkOutput($sformatf("vec%0d.ctrl", v), ctrlW, vecs[v].expCtrl);
    end

    // Abort a write to reg3 during the wait, then confirm reg3 and other regs untouched
    abortXfer(1'b0, 16'h000C, 32'hDEAD_BEEF, 1);
    applyStimulus(1'b0, 1'b0, 16'h000C, 32'h0, rd, span);
    checkOutput("abortReg3", rd, 32'hAAAA_5555);
    applyStimulus(1'b0, 1'b0, 16'h003C, 32'h0, rd, span);
    checkOutput("reg15Untouched", rd, 32'h0);

    // Enable without a setup phase is ignored
    driveBus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      checkOutput($sformatf("noSetupReady%0d", i), 32'(busW.oPREADY), 32'd0);
    end
    @(posedge iClk); #1;
    driveBus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);

    // Back-to-back on the zero-wait instance
    applyStimulus(1'b1, 1'b1, 16'h0004, 32'h0BAD_F00D, rd, span);
    modelWrite(1'b1, 16'h0004, 32'h0BAD_F00D);
    checkOutput("b2bCtrlSpan", 32'(span), 32'd2);
    applyStimulus(1'b1, 1'b1, 16'h000C, 32'h1357_9BDF, rd, span);
    modelWrite(1'b1, 16'h000C, 32'h1357_9BDF);
    checkOutput("b2bWriteSpan", 32'(span), 32'd2);
    applyStimulus(1'b1, 1'b0, 16'h000C, 32'h0, rd, span);
    checkOutput("b2bReadSpan", 32'(span), 32'd2);
    checkOutput("b2bReadData", rd, 32'h1357_9BDF);
    checkOutput("rdataClear", curRdata(1'b1), 32'd0);
    checkOutput("b2bCtrl", ctrlZ, 32'h0BAD_F00D);

    // Reset asserted in the middle of a read that is already presenting data
    applyStimulus(1'b0, 1'b1, 16'h0004, 32'h55AA_33CC, rd, span);
    driveBus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 32'h0);
    @(posedge iClk); #1;
    driveBus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 32'h0);
    @(posedge iClk);
    @(posedge iClk);
    @(negedge iClk);
    checkOutput("preResetReady", 32'(busW.oPREADY), 32'd1);
    checkOutput("preResetRdata", busW.oPRDATA, 32'h55AA_33CC);
    #2 iRsn = 1'b0;
    #1;
    checkOutput("midResetReady", 32'(busW.oPREADY), 32'd0);
    checkOutput("midResetRdata", busW.oPRDATA, 32'd0);
    checkOutput("midResetCtrlW", ctrlW, 32'd0);
    checkOutput("midResetCtrlZ", ctrlZ, 32'd0);
    driveBus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    modelReset();
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRsn = 1'b1;
    @(posedge iClk); #1;

    // Random transfers against the reference map, with occasional aborts
    for (int n = 0; n < 250; n++) begin
      bit          z, wr, ab;
      int          idx, hold;
      logic [15:0] addr;
      logic [31:0] d;
      z    = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      ab   = ($urandom_range(0, 7) == 0);
      idx  = $urandom_range(0, 19);
      addr = 16'(idx * 4 + $urandom_range(0, 3));
      d    = $urandom;
      status = $urandom;
      if (ab) begin
        hold = z ? 0 : $urandom_range(0, 2);
        abortXfer(z, addr, d, hold);
      end else begin
        applyStimulus(z, wr, addr, d, rd, span);
        checkOutput($sformatf("rnd%0d.span", n), 32'(span), z ? 32'd2 : 32'd4);
        if (wr) modelWrite(z, addr, d);
        else checkOutput($sformatf("rnd%0d.rdata@%h", n, addr), rd, modelRead(z, addr, status));
        checkOutput($sformatf("rnd%0d.ctrl", n), curCtrl(z), model[z][1]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
